// File: rtl/spike_detect_pkg.sv
// Shared types and defaults for the spike detector.
// Arm/dump state encodings and the channel geometry defaults.
package spike_detect_pkg;

   localparam int          NUM_CH_DEF = 35;
   localparam int          CH_W_DEF   = 6;
   localparam logic [15:0] MEDIAN     = 16'h7FFF;

   typedef enum logic [1:0] {
      UNARMED,
      LOAD,
      ARMED
   } arm_state_t;

   typedef enum logic {
      D_IDLE,
      D_SEND
   } dump_state_t;

endpackage

// File: rtl/spike_bin_dump.sv
// Captures a closed count bin into a shadow array and streams it out
// one channel per cycle; bins closing mid-stream are dropped.
module spike_bin_dump
   import spike_detect_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int CH_W   = CH_W_DEF,
   parameter int CNT_W  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          dump,
   input  logic [NUM_CH-1:0][CNT_W-1:0]  snap,
   output logic [CNT_W-1:0]              count_o,
   output logic                          count_v,
   output logic [CH_W-1:0]               count_ch,
   output logic                          overrun
);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   dump_state_t                  state;
   dump_state_t                  state_nx;
   logic [NUM_CH-1:0][CNT_W-1:0] shadow;
   logic [CH_W-1:0]              nx_ch;

   assign nx_ch = count_ch + CH_W'(1);

   always_comb begin
      state_nx = state;
      unique case (state)
         D_IDLE: if (dump) state_nx = D_SEND;
         D_SEND: if (count_ch == LAST_CH) state_nx = D_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= D_IDLE;
         count_v  <= 1'b0;
         count_ch <= '0;
         count_o  <= '0;
         overrun  <= 1'b0;
      end else begin
         state <= state_nx;
         if (dump && state == D_SEND)
            overrun <= 1'b1;
         unique case (state)
            D_IDLE: begin
               if (dump) begin
                  count_v  <= 1'b1;
                  count_ch <= '0;
                  count_o  <= snap[0];
               end
            end
            D_SEND: begin
               if (count_ch == LAST_CH) begin
                  count_v <= 1'b0;
               end else begin
                  count_ch <= nx_ch;
                  count_o  <= shadow[nx_ch];
               end
            end
         endcase
      end
   end

   // Shadow holds no reset: it is only read after a capture.
   always_ff @(posedge clk) begin
      if (state == D_IDLE && dump)
         shadow <= snap;
   end

endmodule

// File: rtl/spike_detect.sv
// Per-channel threshold-crossing spike detector with refractory
// hold-off and binned spike counts streamed out per frame bin.
module spike_detect
   import spike_detect_pkg::*;
#(
   parameter int NUM_CH  = NUM_CH_DEF,
   parameter int CH_W    = CH_W_DEF,
   parameter int BIN_LEN = 1000,
   parameter int REFRACT = 30,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      raw_data_in,
   input  logic             raw_data_valid,
   input  logic [CH_W-1:0]  channel,
   input  logic [15:0]      threshold_i,
   input  logic             threshold_v,
   input  logic             cal_finish,
   output logic             spike_o,
   output logic [CH_W-1:0]  spike_ch,
   output logic [CNT_W-1:0] count_o,
   output logic             count_v,
   output logic [CH_W-1:0]  count_ch,
   output logic             armed,
   output logic             overrun
);

   localparam int              RW      = $clog2(REFRACT + 1);
   localparam int              FW      = $clog2(BIN_LEN + 1);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   arm_state_t                   arm_q;
   arm_state_t                   arm_nx;
   logic [CH_W-1:0]              wr_idx;
   logic [NUM_CH-1:0][15:0]      thr;
   logic [NUM_CH-1:0]            prev_below;
   logic [NUM_CH-1:0][RW-1:0]    refr;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_nx;
   logic [FW-1:0]                frame;
   logic                         in_range;
   logic                         below;
   logic                         hit;
   logic                         frame_end;
   logic                         dump;

   assign armed     = (arm_q == ARMED);
   assign in_range  = raw_data_valid &&
                      ({1'b0, channel} < (CH_W + 1)'(NUM_CH));
   // Reads the registered threshold, so a same-cycle write is not seen.
   assign below     = raw_data_in < thr[channel];
   assign hit       = armed && in_range && below &&
                      !prev_below[channel] &&
                      (refr[channel] == '0);
   assign frame_end = armed && raw_data_valid && (channel == LAST_CH);
   assign dump      = frame_end && (frame == FW'(BIN_LEN - 1));

   always_comb begin
      arm_nx = arm_q;
      unique case (arm_q)
         UNARMED: if (threshold_v) arm_nx = LOAD;
         LOAD:    if (cal_finish)  arm_nx = ARMED;
         ARMED:   arm_nx = ARMED;
         default: arm_nx = UNARMED;
      endcase
   end

   // Counts including the current spike; this is what a dump captures.
   always_comb begin
      cnt_nx = cnt;
      if (hit && cnt[channel] != CNT_MAX)
         cnt_nx[channel] = cnt[channel] + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (threshold_v)
         thr[wr_idx] <= threshold_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q      <= UNARMED;
         wr_idx     <= '0;
         prev_below <= '0;
         refr       <= '0;
         cnt        <= '0;
         frame      <= '0;
         spike_o    <= 1'b0;
         spike_ch   <= '0;
      end else begin
         arm_q   <= arm_nx;
         spike_o <= hit;
         if (hit)
            spike_ch <= channel;
         if (cal_finish)
            wr_idx <= '0;
         else if (threshold_v && wr_idx != LAST_CH)
            wr_idx <= wr_idx + CH_W'(1);
         if (in_range) begin
            prev_below[channel] <= below;
            if (hit)
               refr[channel] <= RW'(REFRACT);
            else if (refr[channel] != '0)
               refr[channel] <= refr[channel] - RW'(1);
         end
         cnt <= dump ? '0 : cnt_nx;
         if (frame_end)
            frame <= dump ? '0 : frame + FW'(1);
      end
   end

   spike_bin_dump #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W),
      .CNT_W  (CNT_W)
   ) u_dump (
      .clk      (clk),
      .rst_n    (rst_n),
      .dump     (dump),
      .snap     (cnt_nx),
      .count_o  (count_o),
      .count_v  (count_v),
      .count_ch (count_ch),
      .overrun  (overrun)
   );

endmodule

// File: tb/tb_spike_detect.sv
// Bench for spike_detect: two instances (bin of 2 frames and of 1 frame)
// share stimulus and are compared each cycle against a behavioural model.
module tb_spike_detect;
   import spike_detect_pkg::*;

   localparam int NCH  = 35;
   localparam int REF  = 30;
   localparam int CMAX = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] raw_data_in;
   logic        raw_data_valid;
   logic [5:0]  channel;
   logic [15:0] threshold_i;
   logic        threshold_v;
   logic        cal_finish;

   logic       s_o  [2];
   logic [5:0] s_ch [2];
   logic [7:0] c_o  [2];
   logic       c_v  [2];
   logic [5:0] c_ch [2];
   logic       arm  [2];
   logic       ovr  [2];

   always #5 clk = ~clk;

   spike_detect #(.BIN_LEN(2)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .raw_data_in(raw_data_in), .raw_data_valid(raw_data_valid),
      .channel(channel), .threshold_i(threshold_i),
      .threshold_v(threshold_v), .cal_finish(cal_finish),
      .spike_o(s_o[0]), .spike_ch(s_ch[0]),
      .count_o(c_o[0]), .count_v(c_v[0]), .count_ch(c_ch[0]),
      .armed(arm[0]), .overrun(ovr[0])
   );

   spike_detect #(.BIN_LEN(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .raw_data_in(raw_data_in), .raw_data_valid(raw_data_valid),
      .channel(channel), .threshold_i(threshold_i),
      .threshold_v(threshold_v), .cal_finish(cal_finish),
      .spike_o(s_o[1]), .spike_ch(s_ch[1]),
      .count_o(c_o[1]), .count_v(c_v[1]), .count_ch(c_ch[1]),
      .armed(arm[1]), .overrun(ovr[1])
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [15:0] m_thr [NCH];
   int          m_widx;
   bit          m_loaded, m_armed;
   bit          m_pb  [NCH];
   int          m_gap [NCH];
   bit          m_sp;
   int          m_sp_ch;
   int          m_bl   [2] = '{2, 1};
   int          m_cnt  [2][NCH];
   int          m_snap [2][NCH];
   int          m_frame[2];
   int          m_left [2];
   int          m_next [2];
   bit          m_cv   [2];
   int          m_cch  [2];
   int          m_co   [2];
   bit          m_ovr  [2];

   task automatic chk(input int l, input string tag,
                      input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s[dut%0d] t=%0t: observed %0h expected %0h",
                tag, l, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_widx = 0;
      m_loaded = 0;
      m_armed = 0;
      m_sp = 0;
      m_sp_ch = 0;
      for (int i = 0; i < NCH; i++) begin
         m_pb[i] = 0;
         m_gap[i] = REF;
      end
      for (int l = 0; l < 2; l++) begin
         for (int i = 0; i < NCH; i++) m_cnt[l][i] = 0;
         m_frame[l] = 0;
         m_left[l] = 0;
         m_next[l] = 0;
         m_cv[l] = 0;
         m_cch[l] = 0;
         m_co[l] = 0;
         m_ovr[l] = 0;
      end
   endtask

   task automatic model_edge();
      int c;
      bit below, sp, dmp;
      if (!rst_n) return;
      c = int'(channel);
      sp = 0;
      if (raw_data_valid && c < NCH) begin
         below = raw_data_in < m_thr[c];
         sp = m_armed && below && !m_pb[c] && m_gap[c] >= REF;
         m_pb[c] = below;
         if (sp) m_gap[c] = 0;
         else if (m_gap[c] < REF) m_gap[c]++;
      end
      m_sp = sp;
      if (sp) m_sp_ch = c;
      for (int l = 0; l < 2; l++) begin
         if (sp && m_cnt[l][c] < CMAX) m_cnt[l][c]++;
         dmp = 0;
         if (m_armed && raw_data_valid && c == NCH - 1) begin
            m_frame[l]++;
            if (m_frame[l] == m_bl[l]) begin
               m_frame[l] = 0;
               dmp = 1;
            end
         end
         if (dmp) begin
            if (m_cv[l]) begin
               m_ovr[l] = 1;
            end else begin
               for (int i = 0; i < NCH; i++) m_snap[l][i] = m_cnt[l][i];
               m_left[l] = NCH;
               m_next[l] = 0;
            end
            for (int i = 0; i < NCH; i++) m_cnt[l][i] = 0;
         end
         if (m_left[l] > 0) begin
            m_cv[l] = 1;
            m_cch[l] = m_next[l];
            m_co[l] = m_snap[l][m_next[l]];
            m_next[l]++;
            m_left[l]--;
         end else begin
            m_cv[l] = 0;
         end
      end
      if (m_loaded && cal_finish) m_armed = 1;
      if (threshold_v) m_loaded = 1;
      if (threshold_v) m_thr[m_widx] = threshold_i;
      if (cal_finish) m_widx = 0;
      else if (threshold_v && m_widx < NCH - 1) m_widx++;
   endtask

   task automatic check_all();
      for (int l = 0; l < 2; l++) begin
         chk(l, "spike_o",  32'(s_o[l]),  32'(m_sp));
         chk(l, "spike_ch", 32'(s_ch[l]), m_sp_ch);
         chk(l, "armed",    32'(arm[l]),  32'(m_armed));
         chk(l, "count_v",  32'(c_v[l]),  32'(m_cv[l]));
         chk(l, "count_ch", 32'(c_ch[l]), m_cch[l]);
         chk(l, "count_o",  32'(c_o[l]),  m_co[l]);
         chk(l, "overrun",  32'(ovr[l]),  32'(m_ovr[l]));
      end
   endtask

   task automatic step(input bit v, input int ch, input logic [15:0] d,
                       input bit tv, input logic [15:0] t, input bit cf);
      raw_data_valid = v;
      channel = 6'(ch);
      raw_data_in = d;
      threshold_v = tv;
      threshold_i = t;
      cal_finish = cf;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic sample(input int ch, input logic [15:0] d);
      step(1, ch, d, 0, 16'h0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 16'h0, 0);
   endtask

   task automatic load_thr(input logic [15:0] v, input bit arm_it);
      step(0, 0, 16'h0, 0, 16'h0, 1);
      for (int i = 0; i < NCH; i++) step(0, 0, 16'h0, 1, v, 0);
      if (arm_it) step(0, 0, 16'h0, 0, 16'h0, 1);
   endtask

   task automatic frame_all(input logic [15:0] d);
      for (int c = 0; c < NCH; c++) sample(c, d);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      idle(2);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      raw_data_in = '0;
      raw_data_valid = 1'b0;
      channel = '0;
      threshold_i = '0;
      threshold_v = 1'b0;
      cal_finish = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all();
      rst_n = 1'b1;
      idle(2);

      // Not armed until cal_finish: crossings and frames are ignored
      load_thr(16'h7000, 0);
      sample(3, MEDIAN);
      sample(3, 16'h6F00);
      sample(34, MEDIAN);
      step(0, 0, 16'h0, 0, 16'h0, 1);

      // Single spike on ch3 one cycle after the crossing sample
      sample(3, MEDIAN);
      sample(3, 16'h6F00);
      sample(3, 16'h6E00);
      sample(3, MEDIAN);

      // Same-cycle threshold write uses the old threshold
      step(1, 0, 16'h7800, 1, 16'h8000, 0);
      sample(0, 16'h7800);
      load_thr(16'h7000, 1);

      // Refractory: recross at +10 blocked, at +31 accepted
      sample(5, MEDIAN);
      sample(5, 16'h6000);
      for (int i = 1; i <= 31; i++)
         sample(5, (i == 10 || i == 31) ? 16'h6000 : MEDIAN);
      sample(5, MEDIAN);

      // Two-frame bin with one ch0 spike per frame
      do_reset();
      load_thr(16'h7000, 1);
      sample(0, 16'h6000);
      for (int i = 0; i < 31; i++) sample(0, MEDIAN);
      for (int c = 1; c < NCH; c++) sample(c, MEDIAN);
      sample(0, 16'h6000);
      for (int c = 1; c < NCH; c++) sample(c, MEDIAN);
      idle(40);
      frame_all(MEDIAN);
      idle(40);

      // Count saturation: 300 spikes on ch1 in one bin
      for (int k = 0; k < 300; k++) begin
         sample(1, 16'h6000);
         for (int i = 0; i < 31; i++) sample(1, MEDIAN);
      end
      frame_all(MEDIAN);
      frame_all(MEDIAN);
      idle(40);

      // Random traffic incl. out-of-range channels and recalibration
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 3) != 0,
              $urandom_range(0, 40),
              16'($urandom_range(32'h6800, 32'h7800)),
              $urandom_range(0, 15) == 0,
              16'($urandom_range(32'h6C00, 32'h7400)),
              $urandom_range(0, 63) == 0);
      end
      idle(40);

      // Reset in the middle of a dump stream
      frame_all(MEDIAN);
      frame_all(MEDIAN);
      idle(5);
      do_reset();
      idle(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spike_detect.md
SPIKE_DETECT -- requirements
Module: spike_detect

Interface
REQ-001 SHALL have parameter NUM_CH, default 35, number of channels per frame.
REQ-002 SHALL have parameter CH_W, default 6, channel index width.
REQ-003 SHALL have parameter BIN_LEN, default 1000, frames per count bin.
REQ-004 SHALL have parameter REFRACT, default 30, refractory length in same-channel samples.
REQ-005 SHALL have parameter CNT_W, default 8, per-channel bin count width.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clk, input, 1: clock.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port raw_data_in, input, 16: offset-binary sample, midscale 16'h7FFF.
REQ-010 SHALL have port raw_data_valid, input, 1: sample strobe.
REQ-011 SHALL have port channel, input, CH_W: channel of the current sample.
REQ-012 SHALL have port threshold_i, input, 16: threshold from the threshold calculator.
REQ-013 SHALL have port threshold_v, input, 1: threshold strobe, channels delivered in order 0..NUM_CH-1.
REQ-014 SHALL have port cal_finish, input, 1: pulse marking the end of one threshold set.
REQ-015 SHALL have port spike_o, input-side-free output, 1: one-cycle spike pulse.
REQ-016 SHALL have port spike_ch, output, CH_W: channel of spike_o.
REQ-017 SHALL have port count_o, output, CNT_W: bin count, streamed.
REQ-018 SHALL have port count_v, output, 1: count_o valid.
REQ-019 SHALL have port count_ch, output, CH_W: channel of count_o.
REQ-020 SHALL have port armed, output, 1: detection enabled.
REQ-021 SHALL have port overrun, output, 1: sticky bin-dump overrun flag.

Function
REQ-022 SHALL maintain per-channel arrays: thr, prev_below, refr, cnt, plus a shadow count array.
REQ-023 SHALL write threshold_i into thr[wr_idx] on threshold_v, incrementing wr_idx; wr_idx clears on cal_finish and saturates at NUM_CH-1.
REQ-024 SHALL implement arm FSM UNARMED -> LOAD (first threshold_v) -> ARMED (cal_finish); ARMED is terminal until reset, with thresholds updated live on recalibration.
REQ-025 SHALL treat a sample as below when raw_data_in < thr[channel], unsigned compare.
REQ-026 SHALL detect a spike when armed, valid, channel < NUM_CH, below, prev_below[channel]=0, and refr[channel]=0.
REQ-027 SHALL assert spike_o/spike_ch exactly 1 cycle after the qualifying sample.
REQ-028 SHALL update prev_below[channel] on every valid in-range sample, armed or not.
REQ-029 SHALL on a spike load refr[channel]=REFRACT; otherwise, on each valid sample of that channel with refr>0, decrement it.
REQ-030 SHALL on a spike increment cnt[channel], saturating at 2^CNT_W-1.
REQ-031 SHALL, when the same cycle writes thr[ch] and presents a sample on ch, use the old threshold for that sample.
REQ-032 SHALL ignore samples with channel >= NUM_CH entirely.
REQ-033 SHALL count frames on valid samples of channel NUM_CH-1 while armed; at frame BIN_LEN-1 it wraps to 0 and raises a dump.
REQ-034 SHALL on a dump copy cnt into the shadow array including any spike of the closing sample, then clear cnt.
REQ-035 SHALL implement dump FSM D_IDLE -> D_SEND; D_SEND emits count_v for one channel per cycle, 0..NUM_CH-1, then returns to D_IDLE.
REQ-036 SHALL start count_v 1 cycle after the dump sample.
REQ-037 SHALL, on a dump request arriving during D_SEND, set overrun and discard the new bin while the current stream completes.

Reset
REQ-038 SHALL on rst_n low asynchronously clear spike_o, spike_ch, count_o, count_v, count_ch, armed, overrun, both FSMs, wr_idx, frame counter, prev_below, refr, and cnt; thr is undefined until reloaded.
REQ-039 SHALL, when reset asserts mid-stream, abort the stream with no further count_v.

Structure
REQ-040 SHALL place the FSM state encodings and defaults for NUM_CH, CH_W, and Median 16'h7FFF in a shared package.
REQ-041 SHALL have one natural sub-module, spike_bin_dump, implementing the shadow array and dump FSM.

Verification
REQ-042 SHALL cover: load thr=16'h7000 on all channels with cal_finish; drive ch3 samples 7FFF, 6F00, 6E00 -> exactly one spike_o, spike_ch=3, 1 cycle after 6F00.
REQ-043 SHALL cover: with REFRACT=30, ch5 crosses, recovers, and crosses again 10 samples later -> no second spike; a crossing at 31 samples later -> spike.
REQ-044 SHALL cover: crossings before cal_finish -> no spike_o; armed=0 until cal_finish.
REQ-045 SHALL cover: BIN_LEN=2, one spike on ch0 in each of 2 frames -> 35 count_v cycles with ch0=2, all others 0, and cnt cleared.
REQ-046 SHALL cover: BIN_LEN=1 with a stalled stream -> overrun=1 and sticky until reset.
REQ-047 SHALL cover: 300 spikes on ch1 in one bin -> count_o=255.
